systolic2serial: RTL and testbench
==================================

Name: systolic2serial

Overview:
- De-skews the wide, diagonally staggered result vectors leaving the systolic PU and returns them as a single-lane, row-major serial stream with valid/ready handshake.
- It is the return-path counterpart of the input skewer: lane r carries element (r, c) on skewed beat c + r.
- Sits between the PU output port and the AXI-side result writer.

Parameters:
- DATA_SIZE, 8, width of one result element (signed).
- MAX_SYS_PORT, 16, number of PU lanes on the input bus.
- MAX_SYS_HEIGHT, 3, maximum number of active rows H.
- MAX_SYS_WIDTH, 6, maximum number of columns per row W.
- MAX_DEPTH, MAX_SYS_HEIGHT*MAX_SYS_WIDTH, de-skew buffer depth.

Ports:
- i_clk  in  1  clock, rising edge.
- i_n_reset  in  1  reset, asynchronous, active-low.
- i_set_param  in  1  latch i_out_height/i_out_width; pulse.
- i_out_height  in  8  H, active rows.
- i_out_width  in  8  W, columns per row.
- i_terminate  in  1  abort; clears parameters and buffer.
- o_set_param_done  out  1  one-cycle pulse after an accepted set_param.
- o_param_err  out  1  one-cycle pulse after a rejected set_param.
- i_valid  in  1  skewed beat present on i_data.
- i_data  in  DATA_SIZE*MAX_SYS_PORT  skewed lanes; lane k occupies bits [DATA_SIZE*k +: DATA_SIZE].
- o_in_ready  out  1  high only in CAPTURE.
- o_overflow  out  1  sticky flag: i_valid seen while not in CAPTURE.
- o_valid  out  1  serial element valid.
- i_ready  in  1  downstream accept.
- o_data  out  DATA_SIZE  serial element.
- o_last  out  1  qualifies the final element (H*W-1).
- o_done  out  1  one-cycle pulse when the last element is accepted.

Behaviour:
- Reset is asynchronous on i_n_reset low. Every output is 0, every register is 0, buffer is cleared, state is IDLE.
- States: IDLE, CAPTURE, DRAIN.
- Parameter handling (priority: set_param > terminate):
  - i_set_param with 1<=H<=min(MAX_SYS_HEIGHT, MAX_SYS_PORT) and 1<=W<=MAX_SYS_WIDTH: latch H and W, clear buffer and counters, go to CAPTURE, pulse o_set_param_done next cycle.
  - Out-of-range values: pulse o_param_err next cycle; state and parameters are unchanged.
  - i_terminate: clear everything except o_overflow, go to IDLE.
  - o_overflow clears only on reset or on an accepted set_param.
- CAPTURE (beat counter b runs from 0 to W+H-2):
  - On i_valid, for each lane r<H where r<=b<r+W, write lane r into buf[r*W + (b-r)]. All other lanes are ignored.
  - After beat W+H-2 is written, the next cycle is DRAIN. o_valid rises one cycle after that final beat.
  - If i_valid is low, b holds.
- DRAIN (read pointer p runs from 0 to H*W-1):
  - o_valid=1 and o_data=buf[p]; o_data is purely register-sourced, with no combinational path from any input.
  - o_data/o_valid hold stable while i_ready=0.
  - A handshake (o_valid & i_ready) advances p.
  - o_last = (p == H*W-1).
  - On the last handshake: pulse o_done, clear b and p, return to CAPTURE with the same parameters, ready for the next tile.
- Throughput: one element per cycle under continuous i_ready.
- i_valid outside CAPTURE: beat is dropped and o_overflow is set.
- Widths: addresses are clog2(MAX_DEPTH) bits. r*W and b-r are computed in 8 bits and are guaranteed non-negative by the window test.
- Reset mid-DRAIN: o_valid drops immediately (asynchronous). No partial stream is resumed.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/CAPTURE/DRAIN);
  - the clogb2 function;
  - lane slice width constant DATA_SIZE.
- One natural sub-module: systolic2serial_buf, a MAX_DEPTH x DATA_SIZE register file with H-lane parallel write and one read port. Parallel write is safe because per-beat addresses across rows are disjoint.
- The FSM and counters stay in the top level.

Test Plan:
- Basic de-skew, H=2, W=3:
  - Stimulus: beats (lane0, lane1) = (1,x), (2,4), (3,5), (x,6) with i_ready=1.
  - Required: o_data 1,2,3,4,5,6 on consecutive cycles; o_last only on 6; o_done pulse once; o_in_ready returns high.
- Backpressure, same tile:
  - Stimulus: toggle i_ready 1,0,0,1,... during DRAIN.
  - Required: o_data holds while i_ready=0; sequence still 1..6; no duplicates or drops.
- Max tile, H=3, W=6:
  - Stimulus: lane r, beat b carries 10*r+(b-r); lanes 3..15 driven 0xFF.
  - Required: 18 elements 0..5, 10..15, 20..25; 0xFF never appears.
- Bad parameters:
  - Stimulus: set_param H=4 (MAX_SYS_HEIGHT=3), then W=0.
  - Required: o_param_err pulses twice; o_set_param_done stays 0; previous H/W and state remain.
- Overflow:
  - Stimulus: i_valid asserted during DRAIN.
  - Required: o_overflow=1 and stays set; drain output unchanged; cleared by the next accepted set_param.
- Terminate/reset:
  - Stimulus: i_terminate at beat 2 of CAPTURE.
  - Required: state IDLE; o_in_ready=0.
  - Stimulus: reset asserted mid-DRAIN.
  - Required: o_valid=0 asynchronously; all outputs 0.

Source files
------------

// File: rtl/systolic2serial_pkg.sv
// Shared constants, state encoding and helpers for the systolic result de-skewer.
package systolic2serial_pkg;

  localparam int DATA_SIZE      = 8;
  localparam int MAX_SYS_PORT   = 16;
  localparam int MAX_SYS_HEIGHT = 3;
  localparam int MAX_SYS_WIDTH  = 6;
  localparam int MAX_DEPTH      = MAX_SYS_HEIGHT * MAX_SYS_WIDTH;

  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int ADDR_W = clogb2(MAX_DEPTH);
  // Active rows are bounded by both the row limit and the number of PU lanes.
  localparam int MAX_H  = (MAX_SYS_HEIGHT < MAX_SYS_PORT) ? MAX_SYS_HEIGHT : MAX_SYS_PORT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/systolic2serial_if.sv
// Skewed input bus plus serial output stream of the de-skewer.
interface systolic2serial_if;
  import systolic2serial_pkg::*;

  logic                             i_valid;
  logic [DATA_SIZE*MAX_SYS_PORT-1:0] i_data;
  logic                             o_in_ready;
  logic                             o_overflow;
  logic                             o_valid;
  logic                             i_ready;
  logic [DATA_SIZE-1:0]             o_data;
  logic                             o_last;
  logic                             o_done;

  modport master (
    input  i_valid, i_data, i_ready,
    output o_in_ready, o_overflow, o_valid, o_data, o_last, o_done
  );

  modport slave (
    output i_valid, i_data, i_ready,
    input  o_in_ready, o_overflow, o_valid, o_data, o_last, o_done
  );

endinterface

// File: rtl/systolic2serial_buf.sv
// De-skew register file: one write port per active row, write-through read port.
module systolic2serial_buf
  import systolic2serial_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [MAX_SYS_HEIGHT-1:0] we,
  input  logic [ADDR_W-1:0]         waddr [MAX_SYS_HEIGHT],
  input  logic [DATA_SIZE-1:0]      wdata [MAX_SYS_HEIGHT],
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_SIZE-1:0]      rdata
);

  logic [DATA_SIZE-1:0] mem_q [MAX_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [MAX_DEPTH];

  // Next contents: rows never collide within one beat, so write order is irrelevant.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '{default: '0};
    end else begin
      for (int r = 0; r < MAX_SYS_HEIGHT; r++) begin
        mem_d[waddr[r]] = we[r] ? wdata[r] : mem_d[waddr[r]];
      end
    end
  end

  // Storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reading next-state contents lets the caller register a word written this cycle.
  assign rdata = mem_d[raddr];

endmodule

// File: rtl/systolic2serial.sv
// Return-path de-skewer: captures diagonally staggered PU result beats and
// replays them as a row-major single-lane valid/ready stream.
module systolic2serial
  import systolic2serial_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_n_reset,
  input  logic                   i_set_param,
  input  logic [7:0]             i_out_height,
  input  logic [7:0]             i_out_width,
  input  logic                   i_terminate,
  output logic                   o_set_param_done,
  output logic                   o_param_err,
  systolic2serial_if.master      bus
);

  state_e               state_q, state_d;
  logic [7:0]           h_q, h_d, w_q, w_d, b_q, b_d;
  logic [ADDR_W-1:0]    p_q, p_d;
  logic                 valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic                 ovf_q, ovf_d, set_done_q, set_done_d, err_q, err_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  logic                      param_ok_s;
  logic [7:0]                tile_n_s, last_beat_s;
  logic                      buf_clr_s;
  logic [MAX_SYS_HEIGHT-1:0] buf_we_s;
  logic [ADDR_W-1:0]         buf_waddr_s [MAX_SYS_HEIGHT];
  logic [DATA_SIZE-1:0]      buf_wdata_s [MAX_SYS_HEIGHT];
  logic [DATA_SIZE-1:0]      buf_rdata_s;
  logic                      unused_lanes_s;

  assign unused_lanes_s = ^bus.i_data[DATA_SIZE*MAX_SYS_PORT-1:DATA_SIZE*MAX_SYS_HEIGHT];
  assign tile_n_s       = h_q * w_q;
  assign last_beat_s    = w_q + h_q - 8'd2;

  // Parameter handling, FSM next state, counters and buffer write steering.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    w_d        = w_q;
    b_d        = b_q;
    p_d        = p_q;
    valid_d    = valid_q;
    last_d     = last_q;
    done_d     = 1'b0;
    set_done_d = 1'b0;
    err_d      = 1'b0;
    buf_clr_s  = 1'b0;
    buf_we_s   = '0;
    for (int r = 0; r < MAX_SYS_HEIGHT; r++) begin
      buf_waddr_s[r] = '0;
      buf_wdata_s[r] = bus.i_data[DATA_SIZE*r +: DATA_SIZE];
    end

    param_ok_s = (i_out_height >= 8'd1) && (i_out_height <= 8'(MAX_H)) &&
                 (i_out_width  >= 8'd1) && (i_out_width  <= 8'(MAX_SYS_WIDTH));
    err_d = i_set_param & ~param_ok_s;
    ovf_d = ovf_q | (bus.i_valid & (state_q != ST_CAPTURE));

    if (i_set_param && param_ok_s) begin
      state_d    = ST_CAPTURE;
      h_d        = i_out_height;
      w_d        = i_out_width;
      b_d        = 8'd0;
      p_d        = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      set_done_d = 1'b1;
      ovf_d      = 1'b0;
      buf_clr_s  = 1'b1;
    end else if (i_terminate) begin
      state_d   = ST_IDLE;
      h_d       = 8'd0;
      w_d       = 8'd0;
      b_d       = 8'd0;
      p_d       = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      buf_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CAPTURE: begin
          if (bus.i_valid) begin
            // Lane r holds column (b - r) of row r while the beat is inside its window.
            for (int r = 0; r < MAX_SYS_HEIGHT; r++) begin
              buf_we_s[r]    = (8'(r) < h_q) && (b_q >= 8'(r)) && (b_q < (8'(r) + w_q));
              buf_waddr_s[r] = ADDR_W'((8'(r) * w_q) + (b_q - 8'(r)));
            end
            if (b_q == last_beat_s) begin
              state_d = ST_DRAIN;
              b_d     = 8'd0;
              p_d     = '0;
              valid_d = 1'b1;
              last_d  = (tile_n_s == 8'd1);
            end else begin
              b_d = b_q + 8'd1;
            end
          end else begin
            b_d = b_q;
          end
        end
        ST_DRAIN: begin
          if (valid_q && bus.i_ready) begin
            if (last_q) begin
              state_d = ST_CAPTURE;
              p_d     = '0;
              b_d     = 8'd0;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              p_d    = p_q + ADDR_W'(1'b1);
              last_d = ((8'(p_q) + 8'd1) == (tile_n_s - 8'd1));
            end
          end else begin
            p_d = p_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output word is prefetched from the buffer at the next read pointer.
  always_comb begin
    if (state_d == ST_DRAIN) begin
      data_d = buf_rdata_s;
    end else begin
      data_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q    <= ST_IDLE;
      h_q        <= 8'd0;
      w_q        <= 8'd0;
      b_q        <= 8'd0;
      p_q        <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      set_done_q <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      w_q        <= w_d;
      b_q        <= b_d;
      p_q        <= p_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      set_done_q <= set_done_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  systolic2serial_buf u_buf (
    .clk   (i_clk),
    .rst_n (i_n_reset),
    .clr   (buf_clr_s),
    .we    (buf_we_s),
    .waddr (buf_waddr_s),
    .wdata (buf_wdata_s),
    .raddr (p_d),
    .rdata (buf_rdata_s)
  );

  assign o_set_param_done = set_done_q;
  assign o_param_err      = err_q;
  assign bus.o_in_ready   = (state_q == ST_CAPTURE);
  assign bus.o_overflow   = ovf_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_last       = last_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_systolic2serial.sv
// Directed self-checking bench for systolic2serial: de-skew, backpressure,
// parameter rejection, overflow, terminate and asynchronous reset.
module tb_systolic2serial;
  import systolic2serial_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       set_param;
  logic [7:0] out_h, out_w;
  logic       terminate;
  logic       set_done, param_err;
  int         total;
  int         bad;
  logic [7:0] exp_q [$];

  systolic2serial_if bus ();

  systolic2serial dut (
    .i_clk            (clk),
    .i_n_reset        (rst_n),
    .i_set_param      (set_param),
    .i_out_height     (out_h),
    .i_out_width      (out_w),
    .i_terminate      (terminate),
    .o_set_param_done (set_done),
    .o_param_err      (param_err),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Lanes 0..2 carry the given bytes; all higher lanes are filled with 0xFF.
  function automatic logic [DATA_SIZE*MAX_SYS_PORT-1:0] mk(input logic [7:0] l0, input logic [7:0] l1,
                                                          input logic [7:0] l2);
    logic [DATA_SIZE*MAX_SYS_PORT-1:0] d;
    d        = {(DATA_SIZE*MAX_SYS_PORT){1'b1}};
    d[7:0]   = l0;
    d[15:8]  = l1;
    d[23:16] = l2;
    return d;
  endfunction

  task automatic do_param(input logic [7:0] h, input logic [7:0] w, input logic ok);
    set_param = 1'b1;
    out_h     = h;
    out_w     = w;
    @(negedge clk);
    set_param = 1'b0;
    check("set_param_done", set_done, ok);
    check("param_err", param_err, !ok);
  endtask

  task automatic beat(input logic [DATA_SIZE*MAX_SYS_PORT-1:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // Consume exp_q; mode 0 = always ready, mode 1 = ready 1,0,0 repeating.
  task automatic drain(input int mode, input logic ovf);
    int         got;
    int         cyc;
    int         dones;
    logic       stalled;
    logic [7:0] prev;
    got = 0; cyc = 0; dones = 0; stalled = 1'b0; prev = 8'd0;
    while (got < exp_q.size() && cyc < 200) begin
      bus.i_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bus.i_valid = ovf && (cyc == 0);
      bus.i_data  = mk(8'hAA, 8'hAA, 8'hAA);
      if (bus.o_done) dones++;
      if (stalled) check("hold_data", bus.o_data, prev);
      if (bus.o_valid && bus.i_ready) begin
        check("data", bus.o_data, exp_q[got]);
        check("last", bus.o_last, got == exp_q.size() - 1);
        got++;
        stalled = 1'b0;
      end else if (bus.o_valid) begin
        stalled = 1'b1;
        prev    = bus.o_data;
      end else begin
        stalled = 1'b0;
      end
      cyc++;
      @(negedge clk);
      bus.i_valid = 1'b0;
    end
    check("drain_count", got, exp_q.size());
    check("early_done", dones, 0);
    if (mode == 0) check("throughput", cyc, exp_q.size());
    check("done_pulse", bus.o_done, 1'b1);
    check("valid_after", bus.o_valid, 1'b0);
    check("in_ready_after", bus.o_in_ready, 1'b1);
    @(negedge clk);
    check("done_one_cycle", bus.o_done, 1'b0);
  endtask

  task automatic tile_2x3();
    beat(mk(8'd1, 8'hEE, 8'hEE));
    beat(mk(8'd2, 8'd4, 8'hEE));
    beat(mk(8'd3, 8'd5, 8'hEE));
    beat(mk(8'hEE, 8'd6, 8'hEE));
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; set_param = 1'b0; out_h = 8'd0; out_w = 8'd0; terminate = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_in_ready", bus.o_in_ready, 1'b0);
    check("rst_overflow", bus.o_overflow, 1'b0);
    check("rst_data", bus.o_data, 8'd0);
    check("rst_done", {set_done, param_err, bus.o_done, bus.o_last}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic de-skew, then the same tile under backpressure.
    do_param(8'd2, 8'd3, 1'b1);
    check("in_ready_capture", bus.o_in_ready, 1'b1);
    tile_2x3();
    drain(0, 1'b0);
    tile_2x3();
    drain(1, 1'b0);

    // Overflow during drain leaves the stream intact and stays sticky.
    tile_2x3();
    drain(0, 1'b1);
    check("overflow_set", bus.o_overflow, 1'b1);

    // Rejected parameters keep previous H/W and the CAPTURE state.
    do_param(8'd4, 8'd3, 1'b0);
    do_param(8'd2, 8'd0, 1'b0);
    check("err_keeps_state", bus.o_in_ready, 1'b1);
    check("overflow_sticky", bus.o_overflow, 1'b1);
    tile_2x3();
    drain(0, 1'b0);

    // Single-element tile: first beat is also the last.
    do_param(8'd1, 8'd1, 1'b1);
    check("overflow_cleared", bus.o_overflow, 1'b0);
    beat(mk(8'd42, 8'hFF, 8'hFF));
    exp_q = '{8'd42};
    drain(0, 1'b0);

    // Maximum tile.
    do_param(8'd3, 8'd6, 1'b1);
    for (int b = 0; b < 8; b++) begin
      logic [7:0] l [3];
      for (int r = 0; r < 3; r++) begin
        l[r] = (b >= r && b < r + 6) ? 8'(10 * r + (b - r)) : 8'hFF;
      end
      beat(mk(l[0], l[1], l[2]));
    end
    exp_q = {};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) exp_q.push_back(8'(10 * r + c));
    end
    drain(0, 1'b0);

    // Terminate at beat 2 of a capture.
    beat(mk(8'd0, 8'hFF, 8'hFF));
    beat(mk(8'd1, 8'd10, 8'hFF));
    terminate   = 1'b1;
    bus.i_valid = 1'b1;
    @(negedge clk);
    terminate   = 1'b0;
    bus.i_valid = 1'b0;
    check("term_in_ready", bus.o_in_ready, 1'b0);
    check("term_valid", bus.o_valid, 1'b0);
    check("term_overflow", bus.o_overflow, 1'b0);

    // Asynchronous reset in the middle of a drain.
    do_param(8'd2, 8'd3, 1'b1);
    tile_2x3();
    check("pre_reset_valid", bus.o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bus.o_valid, 1'b0);
    check("async_data", bus.o_data, 8'd0);
    check("async_in_ready", bus.o_in_ready, 1'b0);
    check("async_flags", {set_done, param_err, bus.o_done, bus.o_last, bus.o_overflow}, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
